// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES controller reader: FSM states and the
// bit positions of each button in the reported byte.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/pad_sync.sv
// Two-flop synchronizer for the controller's serial data line.
// Resets to 1, the idle (released) level of the active-low pad output.
module pad_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller reader: latches the pad, clocks out eight buttons and
// reports the completed frame plus newly pressed buttons with a valid pulse.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int CLK_DIV     = 6,
  parameter int POLL_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       poll_req,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic [7:0] new_press,
  output logic       valid,
  output logic       busy
);

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

  state_t     state_reg;
  logic [7:0] phase_reg;
  logic [7:0] shift_reg;
  logic [7:0] shift_next;
  logic [7:0] buttons_reg;
  logic [7:0] new_press_reg;
  logic [2:0] index_reg;
  logic       half_reg;
  logic       pad_latch_reg;
  logic       pad_clk_reg;
  logic       valid_reg;
  logic       sync_data;
  logic       auto_req;
  logic       phase_end;
  logic       start;

  pad_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pad_data),
    .sync_out (sync_data)
  );

  generate
    if (POLL_CYCLES > 0) begin : g_poll
      localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
      localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
      logic [PW-1:0] poll_reg;

      always_ff @(posedge clk) begin
        if (rst || poll_reg == POLL_LAST) begin
          poll_reg <= '0;
        end else begin
          poll_reg <= poll_reg + PW'(1);
        end
      end

      assign auto_req = (poll_reg == POLL_LAST);
    end else begin : g_no_poll
      assign auto_req = 1'b0;
    end
  endgenerate

  assign phase_end = (phase_reg == PHASE_LAST);
  assign start     = enable & (poll_req | auto_req);

  // Shift contents including the bit being sampled this cycle, so the final
  // bit can be published in the same edge that enters DONE.
  always_comb begin
    shift_next            = shift_reg;
    shift_next[index_reg] = ~sync_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= '0;
      shift_reg     <= '0;
      buttons_reg   <= '0;
      new_press_reg <= '0;
      index_reg     <= '0;
      half_reg      <= 1'b0;
      pad_latch_reg <= 1'b0;
      pad_clk_reg   <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      phase_reg <= phase_end ? 8'd0 : phase_reg + 8'd1;
      case (state_reg)
        ST_IDLE: begin
          phase_reg <= '0;
          if (start) begin
            state_reg     <= ST_LATCH;
            index_reg     <= '0;
            half_reg      <= 1'b0;
            pad_latch_reg <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (phase_end) begin
            half_reg <= 1'b1;
            if (half_reg) begin
              state_reg     <= ST_LOW;
              pad_latch_reg <= 1'b0;
            end
          end
        end
        ST_LOW: begin
          if (phase_end) begin
            shift_reg <= shift_next;
            if (index_reg == 3'd7) begin
              state_reg     <= ST_DONE;
              buttons_reg   <= shift_next;
              new_press_reg <= shift_next & ~buttons_reg;
              valid_reg     <= 1'b1;
            end else begin
              state_reg   <= ST_HIGH;
              pad_clk_reg <= 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (phase_end) begin
            state_reg   <= ST_LOW;
            index_reg   <= index_reg + 3'd1;
            pad_clk_reg <= 1'b0;
          end
        end
        ST_DONE: begin
          phase_reg <= '0;
          state_reg <= ST_IDLE;
        end
        default: begin
          phase_reg <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign pad_latch = pad_latch_reg;
  assign pad_clk   = pad_clk_reg;
  assign buttons   = buttons_reg;
  assign new_press = new_press_reg;
  assign valid     = valid_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: table and random frames against a cycle-position
// model of the pad waveform, plus reset, enable and auto-poll sequences.
module tb_nes_pad_reader;
  import nes_pad_pkg::*;

  localparam int D     = 4;
  localparam int FRAME = 17 * D + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, enable = 1'b1, poll_req = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, valid, busy;
  logic [7:0] buttons, new_press;

  logic       rst_a = 1'b1, enable_a = 1'b0, poll_req_a = 1'b0, pad_data_a = 1'b1;
  logic       pad_latch_a, pad_clk_a, valid_a, busy_a;
  logic [7:0] buttons_a, new_press_a;

  int vectors = 0;
  int miscompares = 0;

  nes_pad_reader #(.CLK_DIV(D), .POLL_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .poll_req(poll_req), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
    .new_press(new_press), .valid(valid), .busy(busy)
  );

  nes_pad_reader #(.CLK_DIV(D), .POLL_CYCLES(200)) dut_auto (
    .clk(clk), .rst(rst_a), .enable(enable_a), .poll_req(poll_req_a), .pad_data(pad_data_a),
    .pad_latch(pad_latch_a), .pad_clk(pad_clk_a), .buttons(buttons_a),
    .new_press(new_press_a), .valid(valid_a), .busy(busy_a)
  );

  // Controller model: 4021-style shift register, active-low serial output.
  logic [7:0] pad_mask = 8'h00;
  logic [3:0] pad_idx = 4'd8;
  logic       pad_clk_d = 1'b0;
  always @(posedge clk) begin
    pad_clk_d <= pad_clk;
    if (pad_latch) pad_idx <= 4'd0;
    else if (pad_clk && !pad_clk_d && pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
  end
  assign pad_data = pad_idx[3] ? 1'b1 : ~pad_mask[pad_idx[2:0]];

  typedef struct {
    string      name;
    logic [7:0] mask;
    logic [7:0] exp_btn;
    logic [7:0] exp_np;
    int         poll1;
    int         poll2;
  } vec_t;
  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int n, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, n, got, want);
    end
  endtask

  // Expected {pad_latch, pad_clk, valid, busy} n cycles after the start sample.
  function automatic logic [3:0] frame_ctl(input int n);
    int   t;
    logic l, c, v, b;
    t = n - 2 * D - 1;
    l = (n >= 1 && n <= 2 * D);
    c = (t >= 0 && t < 15 * D && ((t / D) % 2) == 1);
    v = (n == FRAME);
    b = (n >= 1 && n <= FRAME);
    return {l, c, v, b};
  endfunction

  task automatic run_frame(input string name, input logic [7:0] mask,
                           input logic [7:0] exp_btn, input logic [7:0] exp_np,
                           input int poll1, input int poll2, input int drop_en);
    pad_mask = mask;
    poll_req = 1'b1;
    tick();
    for (int n = 1; n <= FRAME + 4; n++) begin
      poll_req = (n == poll1 || n == poll2);
      if (n == drop_en) enable = 1'b0;
      check({name, "/ctl"}, n, 32'({pad_latch, pad_clk, valid, busy}), 32'(frame_ctl(n)));
      if (n >= FRAME) begin
        check({name, "/buttons"}, n, 32'(buttons), 32'(exp_btn));
        check({name, "/new_press"}, n, 32'(new_press), 32'(exp_np));
      end
      tick();
    end
    poll_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] prev, m;
    int         frames, exp_l;

    repeat (3) tick();
    check("reset_state", 0, 32'({pad_latch, pad_clk, valid, busy, buttons, new_press}), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", 0, 32'({pad_latch, pad_clk, valid, busy}), 32'd0);

    m = 8'(1 << BTN_A) | 8'(1 << BTN_RIGHT);
    tbl[0] = '{"a_right", m, 8'h81, 8'h81, 10, 40};
    tbl[1] = '{"a_start", 8'h09, 8'h09, 8'h08, 0, 0};
    tbl[2] = '{"all", 8'hFF, 8'hFF, 8'hF6, 0, 0};
    tbl[3] = '{"none", 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[4] = '{"even", 8'h55, 8'h55, 8'h55, 0, 0};
    tbl[5] = '{"odd", 8'hAA, 8'hAA, 8'hAA, 0, 0};
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].name, tbl[i].mask, tbl[i].exp_btn, tbl[i].exp_np,
                tbl[i].poll1, tbl[i].poll2, 0);
    end
    prev = 8'hAA;

    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom);
      run_frame("random", m, m, m & ~prev, int'($urandom_range(2, 30)),
                int'($urandom_range(31, 68)), 0);
      prev = m;
    end

    // Enable dropped mid-frame: frame completes, then requests are ignored.
    m = 8'($urandom);
    run_frame("enable_drop", m, m, m & ~prev, 0, 0, 20);
    prev = m;
    for (int k = 0; k < 20; k++) begin
      poll_req = (k % 5 == 0);
      check("disabled_idle", k, 32'({pad_latch, busy}), 32'd0);
      tick();
    end
    poll_req = 1'b0;
    enable = 1'b1;

    // Reset during HIGH of bit 3 abandons the frame.
    run_frame("pre_reset", 8'hC3, 8'hC3, 8'hC3 & ~prev, 0, 0, 0);
    pad_mask = 8'h5A;
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
    repeat (36) tick();
    check("high_bit3", 37, 32'({pad_clk, busy}), 32'h3);
    rst = 1'b1;
    tick();
    check("mid_frame_reset", 38,
          32'({pad_latch, pad_clk, valid, busy, buttons, new_press}), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      check("no_valid_after_reset", k, 32'({valid, busy}), 32'd0);
      tick();
    end
    m = 8'($urandom);
    run_frame("post_reset", m, m, m, 0, 0, 0);

    // Auto-poll every 200 cycles while enabled; nothing once disabled.
    tick();
    rst_a = 1'b0;
    enable_a = 1'b1;
    frames = 0;
    for (int c = 0; c < 1200; c++) begin
      enable_a = (c < 750);
      exp_l = 0;
      for (int k = 1; k <= 5; k++) begin
        if (200 * k - 1 < 750 && c >= 200 * k && c < 200 * k + 2 * D) exp_l = 1;
      end
      check("auto_latch", c, 32'(pad_latch_a), 32'(exp_l));
      if (valid_a) frames++;
      tick();
    end
    check("auto_frames", 1200, 32'(frames), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
